// File: rtl/enemy_spawn_scheduler_if.sv
// Bundle between the game-state logic / enemy instances and the spawn scheduler.
// The master side drives game status and slot occupancy; the slave side is the scheduler.
interface enemy_spawn_scheduler_if #(
  parameter int NUM_SLOTS  = 2,
  parameter int INTERVAL_W = 5
);
  logic                    run;
  logic                    collision;
  logic [NUM_SLOTS-1:0]    slot_busy;
  logic [NUM_SLOTS-1:0]    spawn_en;
  logic [2*NUM_SLOTS-1:0]  spawn_lane;
  logic [7:0]              spawn_count;
  logic [INTERVAL_W-1:0]   interval;
  logic [1:0]              state;

  modport master (
    output run, collision, slot_busy,
    input  spawn_en, spawn_lane, spawn_count, interval, state
  );

  modport slave (
    input  run, collision, slot_busy,
    output spawn_en, spawn_lane, spawn_count, interval, state
  );
endinterface

// File: rtl/enemy_spawn_scheduler.sv
// Decides when an enemy car enters the track, picks a non-repeating lane from an LFSR,
// and loads the lowest free enemy slot with a one-cycle enable pulse.
module enemy_spawn_scheduler #(
  parameter int         NUM_SLOTS     = 2,
  parameter int         INTERVAL_W    = 5,
  parameter int         INIT_INTERVAL = 15,
  parameter int         MIN_INTERVAL  = 4,
  parameter int         SPEEDUP_EVERY = 8,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic                      spawn_clk,
  input  logic                      reset,
  enemy_spawn_scheduler_if.slave    bus
);

  localparam int SPEED_W = (SPEEDUP_EVERY > 1) ? $clog2(SPEEDUP_EVERY) : 1;
  localparam logic [INTERVAL_W-1:0] INTERVAL_ONE  = INTERVAL_W'(1);
  localparam logic [INTERVAL_W-1:0] INTERVAL_INIT = INTERVAL_W'(INIT_INTERVAL);
  localparam logic [INTERVAL_W-1:0] INTERVAL_MIN  = INTERVAL_W'(MIN_INTERVAL);
  localparam logic [SPEED_W-1:0]    SPEED_LAST    = SPEED_W'(SPEEDUP_EVERY - 1);
  localparam logic [2*NUM_SLOTS-1:0] LANES_CENTER = {NUM_SLOTS{2'b01}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    SPAWN = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t                  state_q;
  logic [INTERVAL_W-1:0]   counter_q;
  logic [INTERVAL_W-1:0]   interval_q;
  logic [SPEED_W-1:0]      speedCnt_q;
  logic [7:0]              spawnCount_q;
  logic [1:0]              lastLane_q;
  logic [7:0]              lfsr_q;
  logic [NUM_SLOTS-1:0]    spawnEn_q;
  logic [2*NUM_SLOTS-1:0]  spawnLane_q;

  logic [7:0]              lfsr_d;
  logic [1:0]              rawLane;
  logic [1:0]              lane_d;
  logic [NUM_SLOTS-1:0]    grant;

  // Lane candidate comes from the current LFSR value; a repeat of the previous lane
  // is bumped to the next lane so consecutive spawns never share one.
  always_comb begin
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    rawLane = (lfsr_q[1:0] == 2'd3) ? 2'd1 : lfsr_q[1:0];
    lane_d  = rawLane;
    if (rawLane == lastLane_q) begin
      lane_d = (rawLane == 2'd2) ? 2'd0 : rawLane + 2'd1;
    end
    grant = ~bus.slot_busy & (bus.slot_busy + NUM_SLOTS'(1));
  end

  // Priority per edge: reset, then collision, then run dropping, then the normal sequence.
  always_ff @(posedge spawn_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      counter_q    <= '0;
      interval_q   <= INTERVAL_INIT;
      speedCnt_q   <= '0;
      spawnCount_q <= '0;
      lastLane_q   <= 2'd1;
      lfsr_q       <= LFSR_SEED;
      spawnEn_q    <= '0;
      spawnLane_q  <= LANES_CENTER;
    end else begin
      lfsr_q    <= lfsr_d;
      spawnEn_q <= '0;
      if (state_q == HALT) begin
        state_q <= HALT;
      end else if (bus.collision && (state_q == COUNT || state_q == SPAWN)) begin
        state_q <= HALT;
      end else if (!bus.run) begin
        state_q   <= IDLE;
        counter_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (!bus.collision) begin
              state_q   <= COUNT;
              counter_q <= '0;
            end
          end
          COUNT: begin
            counter_q <= counter_q + INTERVAL_ONE;
            if (counter_q == interval_q - INTERVAL_ONE) begin
              state_q <= SPAWN;
            end
          end
          SPAWN: begin
            if (|grant) begin
              spawnEn_q <= grant;
              for (int k = 0; k < NUM_SLOTS; k++) begin
                if (grant[k]) begin
                  spawnLane_q[2*k +: 2] <= lane_d;
                end
              end
              lastLane_q <= lane_d;
              counter_q  <= '0;
              state_q    <= COUNT;
              if (spawnCount_q != 8'hFF) begin
                spawnCount_q <= spawnCount_q + 8'd1;
              end
              // The interval shrinks once per SPEEDUP_EVERY spawns, even after the count saturates.
              if (speedCnt_q == SPEED_LAST) begin
                speedCnt_q <= '0;
                if (interval_q > INTERVAL_MIN) begin
                  interval_q <= interval_q - INTERVAL_ONE;
                end
              end else begin
                speedCnt_q <= speedCnt_q + SPEED_W'(1);
              end
            end
          end
          HALT: begin
            state_q <= HALT;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.spawn_en    = spawnEn_q;
  assign bus.spawn_lane  = spawnLane_q;
  assign bus.spawn_count = spawnCount_q;
  assign bus.interval    = interval_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Bench for enemy_spawn_scheduler: directed and randomized stimulus checked every edge
// against a behavioural model built from spawn totals and countdowns.
module tb_enemy_spawn_scheduler;

  localparam int         NUM_SLOTS     = 2;
  localparam int         INTERVAL_W    = 5;
  localparam int         INIT_INTERVAL = 15;
  localparam int         MIN_INTERVAL  = 4;
  localparam int         SPEEDUP_EVERY = 8;
  localparam logic [7:0] LFSR_SEED     = 8'hA5;

  localparam int P_IDLE  = 0;
  localparam int P_COUNT = 1;
  localparam int P_SPAWN = 2;
  localparam int P_HALT  = 3;

  logic spawnClk = 1'b0;
  logic reset    = 1'b1;

  enemy_spawn_scheduler_if #(.NUM_SLOTS(NUM_SLOTS), .INTERVAL_W(INTERVAL_W)) bus ();

  enemy_spawn_scheduler #(
    .NUM_SLOTS    (NUM_SLOTS),
    .INTERVAL_W   (INTERVAL_W),
    .INIT_INTERVAL(INIT_INTERVAL),
    .MIN_INTERVAL (MIN_INTERVAL),
    .SPEEDUP_EVERY(SPEEDUP_EVERY),
    .LFSR_SEED    (LFSR_SEED)
  ) dut (
    .spawn_clk(spawnClk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 spawnClk = ~spawnClk;

  int checks   = 0;
  int failures = 0;
  int edgeNo   = 0;

  // Behavioural model: spawn totals drive interval, a countdown drives timing.
  int         mPhase;
  int         mLeft;
  int         mTotal;
  int         mLast;
  logic [7:0] mLfsr;
  logic [1:0] mEn;
  logic [3:0] mLanes;
  int         prevObsLane;

  function automatic int expInterval();
    int v;
    v = INIT_INTERVAL - mTotal / SPEEDUP_EVERY;
    return (v < MIN_INTERVAL) ? MIN_INTERVAL : v;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edgeNo);
    end
  endtask

  task automatic modelEdge(input logic r, input logic c, input logic rst, input logic [1:0] b);
    logic [7:0] cur;
    int raw, lane;
    bit found;
    if (rst) begin
      mPhase = P_IDLE; mLeft = 0; mTotal = 0; mLast = 1;
      mLfsr = LFSR_SEED; mEn = '0; mLanes = 4'b0101;
      return;
    end
    cur   = mLfsr;
    mLfsr = {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    mEn   = '0;
    if (mPhase == P_HALT) begin
      mPhase = P_HALT;
    end else if (c && (mPhase == P_COUNT || mPhase == P_SPAWN)) begin
      mPhase = P_HALT;
    end else if (!r) begin
      mPhase = P_IDLE;
    end else if (mPhase == P_IDLE) begin
      if (!c) begin
        mPhase = P_COUNT;
        mLeft  = expInterval();
      end
    end else if (mPhase == P_COUNT) begin
      mLeft--;
      if (mLeft == 0) mPhase = P_SPAWN;
    end else begin
      found = 0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (!b[k] && !found) begin
          found = 1;
          raw = int'(cur) % 4;
          if (raw == 3) raw = 1;
          lane = (raw == mLast) ? (raw + 1) % 3 : raw;
          mEn[k] = 1'b1;
          mLanes[2*k +: 2] = 2'(lane);
          mLast = lane;
          mTotal++;
          mPhase = P_COUNT;
          mLeft  = expInterval();
        end
      end
    end
  endtask

  task automatic checkOutput(input logic rstApplied);
    int obsLane;
    int cnt;
    cnt = (mTotal > 255) ? 255 : mTotal;
    checkVal("state", 32'(bus.state), 32'(mPhase));
    checkVal("spawn_en", 32'(bus.spawn_en), 32'(mEn));
    checkVal("spawn_lane", 32'(bus.spawn_lane), 32'(mLanes));
    checkVal("spawn_count", 32'(bus.spawn_count), 32'(cnt));
    checkVal("interval", 32'(bus.interval), 32'(expInterval()));
    if (rstApplied) prevObsLane = 1;
    if (bus.spawn_en !== 2'b00) begin
      checkVal("spawn_en_onehot", 32'($onehot(bus.spawn_en)), 32'd1);
      obsLane = bus.spawn_en[1] ? int'(bus.spawn_lane[3:2]) : int'(bus.spawn_lane[1:0]);
      checks++;
      assert (obsLane !== prevObsLane) else begin
        failures++;
        $error("[TB] FAIL lane_repeat observed=%0d expected_not=%0d", obsLane, prevObsLane);
      end
      prevObsLane = obsLane;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic c, input logic rst, input logic [1:0] b);
    bus.run       = r;
    bus.collision = c;
    bus.slot_busy = b;
    reset         = rst;
    @(posedge spawnClk);
    modelEdge(r, c, rst, b);
    edgeNo++;
    #1;
    checkOutput(rst);
  endtask

  task automatic runToSpawn(input logic [1:0] b);
    int n;
    n = 0;
    while (bus.state !== 2'd2 && n < 100) begin
      applyStimulus(1'b1, 1'b0, 1'b0, b);
      n++;
    end
    checkVal("reach_spawn_bound", 32'(bus.state), 32'd2);
  endtask

  int firstEdge;
  int nSp;
  int spawnTimes[0:400];
  int intervalAfter8;
  int stallLen;
  int n;

  initial begin
    prevObsLane = 1;
    modelEdge(1'b0, 1'b0, 1'b1, 2'b00);

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00);
    checkVal("reset_state", 32'(bus.state), 32'd0);
    checkVal("reset_interval", 32'(bus.interval), 32'd15);
    checkVal("reset_lanes", 32'(bus.spawn_lane), 32'h5);

    // First spawn: 16 edges after run is sampled
    firstEdge = -1;
    for (int i = 0; i < 40 && firstEdge < 0; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
      if (bus.spawn_en !== 2'b00) firstEdge = i;
    end
    checkVal("first_spawn_edge", 32'(firstEdge), 32'd16);
    checkVal("first_spawn_en", 32'(bus.spawn_en), 32'h1);
    checkVal("first_lane_not_center", 32'(bus.spawn_lane[1:0] != 2'd1), 32'd1);
    checkVal("first_interval", 32'(bus.interval), 32'd15);

    // Slot ordering and stall
    runToSpawn(2'b01);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b01);
    checkVal("slot1_when_slot0_busy", 32'(bus.spawn_en), 32'h2);
    runToSpawn(2'b11);
    stallLen = $urandom_range(3, 7);
    repeat (stallLen) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 2'b11);
      checkVal("stall_state", 32'(bus.state), 32'd2);
      checkVal("stall_no_pulse", 32'(bus.spawn_en), 32'h0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b01);
    checkVal("stall_release_slot1", 32'(bus.spawn_en), 32'h2);

    // Speed-up to the floor with free slots
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00);
    nSp = 0; n = 0; intervalAfter8 = -1;
    while (nSp < 96 && n < 3000) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
      if (bus.spawn_en !== 2'b00) begin
        spawnTimes[nSp] = edgeNo;
        nSp++;
        if (nSp == 8) intervalAfter8 = int'(bus.interval);
      end
      n++;
    end
    checkVal("speedup_96_reached", 32'(nSp), 32'd96);
    checkVal("period_initial", 32'(spawnTimes[1] - spawnTimes[0]), 32'd16);
    checkVal("period_before_speedup", 32'(spawnTimes[7] - spawnTimes[6]), 32'd16);
    checkVal("interval_after_8", 32'(intervalAfter8), 32'd14);
    checkVal("period_after_speedup", 32'(spawnTimes[8] - spawnTimes[7]), 32'd15);
    checkVal("interval_floor", 32'(bus.interval), 32'd4);

    // Randomized busy slots and run drops
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 39) != 0, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
    end

    // Collision halt is sticky
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b00);
    checkVal("collision_halt", 32'(bus.state), 32'd3);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 2'($urandom_range(0, 3)));
      checkVal("halt_sticky", 32'(bus.state), 32'd3);
      checkVal("halt_no_pulse", 32'(bus.spawn_en), 32'h0);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00);
    checkVal("halt_reset_idle", 32'(bus.state), 32'd0);

    // Run drop clears the counter but keeps the interval
    repeat (8) applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
    checkVal("run_drop_idle", 32'(bus.state), 32'd0);
    checkVal("run_drop_interval", 32'(bus.interval), 32'd15);
    firstEdge = -1;
    for (int i = 0; i < 40 && firstEdge < 0; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
      if (bus.spawn_en !== 2'b00) firstEdge = i;
    end
    checkVal("rerun_spawn_edge", 32'(firstEdge), 32'd16);

    // Collision on the spawn decision edge
    runToSpawn(2'b00);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b00);
    checkVal("collide_at_spawn_no_pulse", 32'(bus.spawn_en), 32'h0);
    checkVal("collide_at_spawn_halt", 32'(bus.state), 32'd3);

    // Reset on the spawn decision edge
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00);
    runToSpawn(2'b00);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00);
    checkVal("reset_at_spawn_no_pulse", 32'(bus.spawn_en), 32'h0);
    checkVal("reset_at_spawn_state", 32'(bus.state), 32'd0);
    checkVal("reset_at_spawn_count", 32'(bus.spawn_count), 32'd0);
    checkVal("reset_at_spawn_lanes", 32'(bus.spawn_lane), 32'h5);

    // Saturation after 300 spawns
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00);
    nSp = 0; n = 0;
    while (nSp < 302 && n < 6000) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
      if (bus.spawn_en !== 2'b00) begin
        spawnTimes[nSp] = edgeNo;
        nSp++;
      end
      n++;
    end
    checkVal("saturation_reached", 32'(nSp), 32'd302);
    checkVal("saturated_count", 32'(bus.spawn_count), 32'd255);
    checkVal("saturated_interval", 32'(bus.interval), 32'd4);
    checkVal("saturated_period", 32'(spawnTimes[301] - spawnTimes[300]), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
